// File: rtl/pet_pkg.sv
// Shared definitions for the pet input controller: button FSM encoding and
// default timing constants for a 50 MHz clock.
package pet_pkg;

    typedef enum logic [1:0] {
        BTN_ARMED  = 2'd0,
        BTN_HELD   = 2'd1,
        BTN_LOCKED = 2'd2
    } btn_state_t;

    localparam int DEF_DEB_CYC  = 1_000_000;
    localparam int DEF_LONG_CYC = 250_000_000;
    localparam int DEF_COOL_CYC = 50_000_000;

endpackage

// File: rtl/debounce.sv
// One input channel: 2-flop synchronizer, optional inversion, debounced level,
// registered rise pulse, and an idle flag (released and quiet for DEB_CYC cycles).
module debounce #(
    parameter int DEB_CYC = 1_000_000,
    parameter bit INVERT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic idle
);
    localparam int CW = $clog2(DEB_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          active;
    logic [CW-1:0] cnt;
    logic [CW-1:0] quiet;

    assign active = sync2 ^ INVERT;
    assign idle   = (quiet == CW'(DEB_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            quiet <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (active != level) begin
                if (cnt == CW'(DEB_CYC - 1)) begin
                    level <= active;
                    rise  <= active;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            // Idle only counts once the synchronizer shows a settled release.
            if (active || level) begin
                quiet <= '0;
            end else if (quiet != CW'(DEB_CYC)) begin
                quiet <= quiet + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pet_input_ctrl.sv
// Debounced button/sensor front end: one-shot press pulses, a long-press test
// pulse, a light-to-dark pulse and a rate-limited proximity pulse.
module pet_input_ctrl
    import pet_pkg::*;
#(
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int COOL_CYC = DEF_COOL_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_feed_n,
    input  logic btn_heal_n,
    input  logic btn_sel_n,
    input  logic btn_test_n,
    input  logic light_raw,
    input  logic echo_near,
    output logic feeding,
    output logic healing,
    output logic change_state,
    output logic test,
    output logic light_out,
    output logic echo_sig
);
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam int CCW = $clog2(COOL_CYC + 1);

    // Button index: 0 feed, 1 heal, 2 select, 3 test.
    logic [3:0] btn_raw;
    logic [3:0] btn_lvl;
    logic [3:0] btn_rise;
    logic [3:0] btn_idle;
    logic [3:0] press;
    logic       light_lvl, light_rise, light_idle;
    logic       echo_lvl, echo_rise, echo_idle;
    logic       unused;

    btn_state_t state     [4];
    btn_state_t state_nxt [4];

    logic [HW-1:0]  hold;
    logic           test_q;
    logic [CCW-1:0] cool;

    assign btn_raw = {btn_test_n, btn_sel_n, btn_heal_n, btn_feed_n};
    assign unused  = ^{light_lvl, light_idle, echo_lvl, echo_idle};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        debounce #(.DEB_CYC(DEB_CYC), .INVERT(1'b1)) u_deb (
            .clk(clk), .rst(rst), .raw(btn_raw[i]),
            .level(btn_lvl[i]), .rise(btn_rise[i]), .idle(btn_idle[i])
        );
    end

    debounce #(.DEB_CYC(DEB_CYC), .INVERT(1'b0)) u_light (
        .clk(clk), .rst(rst), .raw(light_raw),
        .level(light_lvl), .rise(light_rise), .idle(light_idle)
    );

    debounce #(.DEB_CYC(DEB_CYC), .INVERT(1'b0)) u_echo (
        .clk(clk), .rst(rst), .raw(echo_near),
        .level(echo_lvl), .rise(echo_rise), .idle(echo_idle)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            state[i] <= rst ? BTN_LOCKED : state_nxt[i];
        end
    end

    // LOCKED leaves only after a confirmed release, so a press held through reset is ignored.
    always_comb begin
        press = '0;
        for (int i = 0; i < 4; i++) begin
            state_nxt[i] = state[i];
            case (state[i])
                BTN_ARMED: begin
                    if (btn_rise[i]) begin
                        state_nxt[i] = BTN_HELD;
                        press[i]     = 1'b1;
                    end
                end
                BTN_HELD:   if (!btn_lvl[i]) state_nxt[i] = BTN_ARMED;
                BTN_LOCKED: if (btn_idle[i]) state_nxt[i] = BTN_ARMED;
                default:    state_nxt[i] = BTN_LOCKED;
            endcase
        end
    end

    // The press cycle counts as the first hold cycle; the count saturates at LONG_CYC.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold   <= '0;
            test_q <= 1'b0;
        end else begin
            test_q <= 1'b0;
            if (press[3]) begin
                hold   <= HW'(1);
                test_q <= (LONG_CYC == 1);
            end else if (state[3] == BTN_HELD && btn_lvl[3]) begin
                if (hold != HW'(LONG_CYC)) begin
                    hold   <= hold + 1'b1;
                    test_q <= (hold == HW'(LONG_CYC - 1));
                end
            end else begin
                hold <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cool <= '0;
        end else if (echo_sig) begin
            cool <= CCW'(COOL_CYC);
        end else if (cool != '0) begin
            cool <= cool - 1'b1;
        end
    end

    assign feeding      = press[0];
    assign healing      = press[1];
    assign change_state = press[2];
    assign test         = test_q;
    assign light_out    = light_rise;
    assign echo_sig     = echo_rise && (cool == '0);

endmodule

// File: tb/tb_pet_input_ctrl.sv
// Directed scenarios for each behaviour plus a randomized phase on the feed
// and light channels checked against a sliding-window debounce model.
module tb_pet_input_ctrl;
    localparam int DEB  = 4;
    localparam int LNG  = 20;
    localparam int COOL = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_feed_n = 1'b1, btn_heal_n = 1'b1, btn_sel_n = 1'b1, btn_test_n = 1'b1;
    logic light_raw = 1'b0, echo_near = 1'b0;
    logic feeding, healing, change_state, test, light_out, echo_sig;

    int total = 0;
    int bad   = 0;

    // o bits: 5 feeding, 4 healing, 3 change_state, 2 test, 1 light_out, 0 echo_sig
    logic [5:0] o;
    int cnt [6];
    int first [6];
    int last [6];

    pet_input_ctrl #(.DEB_CYC(DEB), .LONG_CYC(LNG), .COOL_CYC(COOL)) dut (
        .clk(clk), .rst(rst),
        .btn_feed_n(btn_feed_n), .btn_heal_n(btn_heal_n),
        .btn_sel_n(btn_sel_n), .btn_test_n(btn_test_n),
        .light_raw(light_raw), .echo_near(echo_near),
        .feeding(feeding), .healing(healing), .change_state(change_state),
        .test(test), .light_out(light_out), .echo_sig(echo_sig)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs are driven just after posedge; outputs sampled at the following negedge.
    task automatic cyc();
        @(negedge clk);
        o = {feeding, healing, change_state, test, light_out, echo_sig};
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        for (int b = 0; b < 6; b++) begin
            cnt[b] = 0; first[b] = -1; last[b] = -1;
        end
    endtask

    task automatic rec(input int t);
        for (int b = 0; b < 6; b++) begin
            if (o[b]) begin
                if (cnt[b] == 0) first[b] = t;
                last[b] = t;
                cnt[b]++;
            end
        end
    endtask

    // A level flips once the synchronized input (raw delayed two cycles) has
    // disagreed with it for DEB consecutive cycles; a 0->1 flip is seen next cycle.
    task automatic model_step(input bit h[$], input bit lvl_in, output bit lvl_out, output bit pulse);
        int n;
        bit all_diff;
        n = h.size();
        all_diff = 1'b1;
        for (int k = 2; k < 2 + DEB; k++) begin
            if (h[n - 1 - k] == lvl_in) all_diff = 1'b0;
        end
        pulse   = all_diff && !lvl_in;
        lvl_out = all_diff ? !lvl_in : lvl_in;
    endtask

    initial begin
        bit fh[$];
        bit lh[$];
        bit lvl_f, lvl_l, exp_f, exp_l, fv, lv;
        int frun, lrun;

        rst = 1'b1;
        repeat (3) cyc();
        check("reset_outputs", o, 0);
        rst = 1'b0;
        repeat (12) cyc();
        check("idle_outputs", o, 0);

        // Single long feed press: one pulse, latency DEB+2, no repeat.
        clear_rec();
        for (int t = 0; t < 40; t++) begin
            btn_feed_n = (t < 30) ? 1'b0 : 1'b1;
            cyc(); rec(t);
        end
        check("feed_count", cnt[5], 1);
        check("feed_latency", first[5], DEB + 2);
        check("feed_no_select", cnt[3], 0);
        repeat (10) cyc();

        // Bouncing heal press settles into one pulse.
        clear_rec();
        for (int t = 0; t < 50; t++) begin
            if (t < 20) btn_heal_n = ((t / 2) % 2 == 1);
            else        btn_heal_n = (t >= 40);
            cyc(); rec(t);
        end
        check("heal_bounce_count", cnt[4], 1);
        check("heal_bounce_at", first[4], 20 + DEB + 2);
        repeat (10) cyc();

        // Short test hold then long hold: one pulse at DEB+2+LNG into the long hold.
        clear_rec();
        for (int t = 0; t < 90; t++) begin
            btn_test_n = (t < 15 || (t >= 25 && t < 65)) ? 1'b0 : 1'b1;
            cyc(); rec(t);
        end
        check("test_count", cnt[2], 1);
        check("test_at", first[2], 25 + DEB + 2 + LNG);
        check("test_no_feed", cnt[5], 0);
        repeat (10) cyc();

        // Simultaneous feed and heal press.
        clear_rec();
        for (int t = 0; t < 30; t++) begin
            btn_feed_n = (t >= 12);
            btn_heal_n = (t >= 12);
            cyc(); rec(t);
        end
        check("both_feed_at", first[5], DEB + 2);
        check("both_heal_at", first[4], DEB + 2);
        check("both_feed_count", cnt[5], 1);

        // Light: pulse on dark only, nothing on return to light.
        clear_rec();
        for (int t = 0; t < 30; t++) begin
            light_raw = (t < 15);
            cyc(); rec(t);
        end
        check("light_count", cnt[1], 1);
        check("light_at", first[1], DEB + 2);

        // Echo: second near-edge falls inside cooldown and is dropped.
        clear_rec();
        for (int t = 0; t < 50; t++) begin
            echo_near = (t < 4) || (t >= 8 && t < 13) || (t >= 20 && t < 36);
            cyc(); rec(t);
        end
        check("echo_count", cnt[0], 2);
        check("echo_first", first[0], DEB + 2);
        check("echo_last", last[0], 20 + DEB + 2);

        // Reset mid-debounce aborts the press; the held button stays locked.
        clear_rec();
        for (int t = 0; t < 20; t++) begin
            btn_feed_n = (t >= 16);
            rst = (t == 3 || t == 4);
            cyc(); rec(t);
        end
        check("reset_abort_feed", cnt[5], 0);
        repeat (20) cyc();

        // Select held through reset is locked out; a fresh press fires.
        // Light dark through reset pulses DEB+2 after release.
        btn_sel_n = 1'b0;
        light_raw = 1'b1;
        rst = 1'b1;
        repeat (3) cyc();
        check("reset_outputs_active_inputs", o, 0);
        rst = 1'b0;
        clear_rec();
        for (int t = 0; t < 50; t++) begin
            btn_sel_n = (t < 20 || t >= 30) ? 1'b0 : 1'b1;
            cyc(); rec(t);
        end
        check("sel_count", cnt[3], 1);
        check("sel_at", first[3], 30 + DEB + 2);
        check("light_after_reset_at", first[1], DEB + 2);
        check("light_after_reset_count", cnt[1], 1);
        btn_sel_n = 1'b1;
        light_raw = 1'b0;
        repeat (20) cyc();

        // Randomized feed and light runs against the window model.
        repeat (8) begin
            fh.push_back(1'b0);
            lh.push_back(1'b0);
        end
        lvl_f = 0; lvl_l = 0; exp_f = 0; exp_l = 0;
        frun = 0; lrun = 0; fv = 0; lv = 0;
        for (int t = 0; t < 400; t++) begin
            if (frun == 0) begin
                fv = 1'($urandom_range(0, 1));
                frun = $urandom_range(1, 12);
            end
            if (lrun == 0) begin
                lv = 1'($urandom_range(0, 1));
                lrun = $urandom_range(1, 12);
            end
            frun--;
            lrun--;
            btn_feed_n = !fv;
            light_raw  = lv;
            fh.push_back(fv);
            lh.push_back(lv);
            cyc();
            check("rnd_feed", o[5], exp_f);
            check("rnd_light", o[1], exp_l);
            model_step(fh, lvl_f, lvl_f, exp_f);
            model_step(lh, lvl_l, lvl_l, exp_l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
